// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit: signed/unsigned MUL, MULH, DIV, REM, one bit per cycle.
// Valid/ready handshakes on both request and result; flag bus ordering matches the ALU.
// Optional build macro ALU_MULDIV_EARLY_OUT_EN: multiplies finish as soon as the remaining
// multiplier bits are all zero (results identical, divide latency unchanged).
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_rs,
  input  logic [WIDTH-1:0] data_rt,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [1:0] {SpNone, SpDivZero, SpOvf} special_e;

  state_e             state_q, state_d;
  special_e           spec_q, spec_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  // a: multiplier (shifts right) or dividend turning into quotient (shifts left)
  logic [WIDTH-1:0]   a_q, a_d;
  // b: multiplicand (shifts left) or divisor in the low word
  logic [2*WIDTH-1:0] b_q, b_d;
  // acc: product accumulator or partial remainder in the low word
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         flags_q, flags_d;

  logic             in_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             mul_last, finish;
  logic [WIDTH:0]   div_tmp, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, fin_res;
  logic             fin_ovf, fin_dz;

  function automatic logic [4:0] make_flags(logic [WIDTH-1:0] res, logic ovf, logic dz);
    logic zero;
    zero = (res == '0);
    return {dz, ovf, res[WIDTH-1], !zero, zero};
  endfunction

  assign in_signed = !op[2];
  assign rs_neg    = in_signed & data_rs[WIDTH-1];
  assign rt_neg    = in_signed & data_rt[WIDTH-1];
  assign rs_mag    = rs_neg ? -data_rs : data_rs;
  assign rt_mag    = rt_neg ? -data_rt : data_rt;

`ifdef ALU_MULDIV_EARLY_OUT_EN
  assign mul_last = (a_q == '0);
`else
  assign mul_last = (cnt_q == CntW'(WIDTH));
`endif

  // Special divides also spend one RUN cycle so they land in DONE one edge after accept.
  assign finish = (spec_q != SpNone) || (op_q[1] ? (cnt_q == CntW'(WIDTH)) : mul_last);

  assign div_tmp  = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, b_q[WIDTH-1:0]};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -a_q : a_q;
  assign rem_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  // Final result and exception flags from the iteration registers and sign fixup
  always_comb begin
    fin_res = '0;
    fin_ovf = 1'b0;
    fin_dz  = 1'b0;
    if (spec_q == SpDivZero) begin
      fin_dz  = 1'b1;
      fin_res = (op_q[1:0] == 2'b11) ? a_q : '1;
    end else if (spec_q == SpOvf) begin
      fin_ovf = 1'b1;
      fin_res = (op_q[1:0] == 2'b11) ? '0 : MinVal;
    end else begin
      unique case (op_q[1:0])
        2'b00: begin
          fin_res = prod_fix[WIDTH-1:0];
          fin_ovf = op_q[2] ? (prod_fix[2*WIDTH-1:WIDTH] != '0)
                            : (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
        end
        2'b01:   fin_res = prod_fix[2*WIDTH-1:WIDTH];
        2'b10:   fin_res = quo_fix;
        default: fin_res = rem_fix;
      endcase
    end
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d  = state_q;
    spec_d   = spec_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          op_d   = op;
          cnt_d  = '0;
          acc_d  = '0;
          a_d    = op[1] ? rs_mag : rt_mag;
          b_d    = {{WIDTH{1'b0}}, (op[1] ? rt_mag : rs_mag)};
          // Remainder follows the dividend; everything else follows the operand sign product
          neg_d  = (op[1:0] == 2'b11) ? rs_neg : (rs_neg ^ rt_neg);
          spec_d = SpNone;
          if (op[1] && (data_rt == '0)) begin
            spec_d = SpDivZero;
            a_d    = data_rs;
          end else if (op[1] && in_signed && (data_rs == MinVal) && (data_rt == '1)) begin
            spec_d = SpOvf;
          end
          state_d = StRun;
        end
      end
      StRun: begin
        if (finish) begin
          result_d = fin_res;
          flags_d  = make_flags(fin_res, fin_ovf, fin_dz);
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (op_q[1]) begin
            // Restoring step: a borrow in the top bit means the trial subtract failed
            if (!div_diff[WIDTH]) begin
              acc_d[WIDTH-1:0] = div_diff[WIDTH-1:0];
              a_d = {a_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d[WIDTH-1:0] = div_tmp[WIDTH-1:0];
              a_d = {a_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (a_q[0]) acc_d = acc_q + b_q;
            b_d = b_q << 1;
            a_d = a_q >> 1;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      spec_q   <= SpNone;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      spec_q   <= spec_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv (WIDTH = 32) against an arithmetic model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_rs;
  logic [31:0] data_rt;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_rs  (data_rs),
    .data_rt  (data_rt),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit / integer arithmetic on the architectural rules
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [4:0] f, output int lat);
    logic        sgn;
    logic [63:0] pa, pb, p;
    logic        ovf, dz;
    logic [31:0] mag;
    int          sa, sb;
    sgn = !o[2];
    ovf = 1'b0;
    dz  = 1'b0;
    lat = 33;
    mag = '0;
    if (!o[1]) begin
      pa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      pb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      p  = pa * pb;
      r  = o[0] ? p[63:32] : p[31:0];
      if (!o[0]) ovf = sgn ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'h0);
`ifdef ALU_MULDIV_EARLY_OUT_EN
      mag = (sgn && b[31]) ? -b : b;
      lat = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) lat = i + 2;
`endif
    end else if (b == 32'h0) begin
      r   = o[0] ? a : 32'hFFFF_FFFF;
      dz  = 1'b1;
      lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r   = o[0] ? 32'h0 : 32'h8000_0000;
      ovf = 1'b1;
      lat = 1;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      r  = o[0] ? sa % sb : sa / sb;
    end else begin
      r = o[0] ? a % b : a / b;
    end
    f = {dz, ovf, r[31], (r != 32'h0), (r == 32'h0)};
  endfunction

  // One request/response; hold > 0 keeps out_ready low and pokes in_valid while in DONE
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input int hold);
    logic [31:0] exp_res;
    logic [4:0]  exp_fl;
    int          exp_lat;
    int          lat;
    model(o, a, b, exp_res, exp_fl, exp_lat);
    @(negedge clk);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op       = o;
    data_rs  = a;
    data_rt  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    data_rs  = $urandom;
    data_rt  = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".result"}, 64'(result), 64'(exp_res));
    check({tag, ".flags"}, 64'(flags), 64'(exp_fl));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op       = 3'($urandom);
      data_rs  = $urandom;
      data_rt  = $urandom;
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".hold_result"}, 64'(result), 64'(exp_res));
      check({tag, ".hold_flags"}, 64'(flags), 64'(exp_fl));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".retire"}, 64'(out_valid), 64'd0);
    check({tag, ".kept"}, 64'(result), 64'(exp_res));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'b000;
    data_rs   = '0;
    data_rt   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd0);
    check("reset.result", 64'(result), 64'd0);
    check("reset.flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset.in_ready_after", 64'(in_ready), 64'd1);

    do_op(3'b100, 32'hFFFF_FFFF, 32'd2, "mulu_ovf", 0);
    do_op(3'b001, 32'hFFFF_FFFD, 32'd5, "mulh_s", 0);
    do_op(3'b000, 32'hFFFF_FFFD, 32'd5, "mul_s", 0);
    do_op(3'b010, 32'hFFFF_FFF9, 32'd2, "div_s", 0);
    do_op(3'b011, 32'hFFFF_FFF9, 32'd2, "rem_s", 0);
    do_op(3'b110, 32'd100, 32'd7, "divu", 0);
    do_op(3'b111, 32'd100, 32'd7, "remu", 0);
    do_op(3'b010, 32'd5, 32'd0, "div_by0", 0);
    do_op(3'b011, 32'd5, 32'd0, "rem_by0", 0);
    do_op(3'b011, 32'hFFFF_FFF0, 32'd0, "rem_by0_neg", 0);
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
    do_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);
    do_op(3'b000, 32'd9, 32'd3, "mul_small", 0);
    do_op(3'b100, 32'd1234, 32'd0, "mul_zero", 0);
    do_op(3'b110, 32'hDEAD_BEEF, 32'd1, "divu_one", 10);

    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    in_valid = 1'b1;
    op       = 3'b100;
    data_rs  = 32'h1234_5678;
    data_rt  = 32'h8765_4321;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.result", 64'(result), 64'd0);
    check("abort.flags", 64'(flags), 64'd0);
    check("abort.in_ready_in_rst", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.idle", 64'(out_valid), 64'd0);

    for (int n = 0; n < 200; n++) begin
      do_op(3'($urandom), pick_operand(), pick_operand(), "rand", (n % 25 == 0) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
